// File: rtl/calculator_axil_engine_if.sv
// rtl/calculator_axil_engine_if.sv - AXI4-Lite bus bundle for the calculator engine
// Purpose: groups the five AXI4-Lite channels (AW, W, B, AR, R) of the S00_AXI port.
// Ports  : none; modport slave is used by the engine, modport master by the bus driver.
interface calculator_axil_engine_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   s00_axi_awaddr;
    logic [2:0]          s00_axi_awprot;
    logic                s00_axi_awvalid;
    logic                s00_axi_awready;
    logic [DATA_W-1:0]   s00_axi_wdata;
    logic [DATA_W/8-1:0] s00_axi_wstrb;
    logic                s00_axi_wvalid;
    logic                s00_axi_wready;
    logic [1:0]          s00_axi_bresp;
    logic                s00_axi_bvalid;
    logic                s00_axi_bready;
    logic [ADDR_W-1:0]   s00_axi_araddr;
    logic [2:0]          s00_axi_arprot;
    logic                s00_axi_arvalid;
    logic                s00_axi_arready;
    logic [DATA_W-1:0]   s00_axi_rdata;
    logic [1:0]          s00_axi_rresp;
    logic                s00_axi_rvalid;
    logic                s00_axi_rready;

    modport slave (
        input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        input  s00_axi_bready,
        input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        input  s00_axi_rready,
        output s00_axi_awready, s00_axi_wready,
        output s00_axi_bresp, s00_axi_bvalid,
        output s00_axi_arready,
        output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
    );

    modport master (
        output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        output s00_axi_bready,
        output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        output s00_axi_rready,
        input  s00_axi_awready, s00_axi_wready,
        input  s00_axi_bresp, s00_axi_bvalid,
        input  s00_axi_arready,
        input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
    );
endinterface

// File: rtl/calculator_axil_engine.sv
// rtl/calculator_axil_engine.sv - AXI4-Lite ADD/SUB/MUL/DIV engine with status and sticky flags
// Purpose: software loads OPA/OPB, writes CTRL.START, polls STATUS (or takes irq), reads RES_LO/RES_HI.
// Ports  : s00_axi_aclk    - clock
//          s00_axi_aresetn - synchronous active-low reset
//          s00_axi         - AXI4-Lite slave (calculator_axil_engine_if.slave)
//          irq             - level interrupt, only when CALC_IRQ_EN is defined
// Macro  : CALC_IRQ_EN enables the IRQ_EN register at 0x18 and the irq output.
module calculator_axil_engine #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int OPERAND_WIDTH      = 32
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    calculator_axil_engine_if.slave s00_axi
`ifdef CALC_IRQ_EN
    ,
    output logic                    irq
`endif
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int W  = OPERAND_WIDTH;
    localparam int PW = 2 * OPERAND_WIDTH;
    localparam int CW = $clog2(OPERAND_WIDTH + 1);

    localparam logic [2:0] A_CTRL = 3'd0, A_OPA = 3'd1, A_OPB = 3'd2, A_RLO = 3'd3;
    localparam logic [2:0] A_RHI  = 3'd4, A_ST  = 3'd5, A_IRQ = 3'd6;
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_awready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]      r_bresp;
    logic [DW-1:0]   r_rdata, w_rdata;
    logic [1:0]      r_op, r_op_l;
    logic [W-1:0]    r_opa, r_opb, r_a, r_b, r_res_lo, r_res_hi, r_quo, r_rem;
    logic [CW-1:0]   r_cnt;
    logic            r_done, r_dz, r_carry;
    logic            r_irq_en;

    logic [2:0]      w_waddr, w_raddr;
    logic            w_wr, w_rd, w_busy, w_wr_err, w_start;
    logic [DW-1:0]   w_wmask, w_wbits, w_opa_nxt, w_opb_nxt;
    logic [1:0]      w_ctrl_op;
    logic [2:0]      w_clr;
    logic [W:0]      w_sum, w_diff, w_shift, w_sub;
    logic [PW-1:0]   w_prod;
    logic            w_fin, w_set_carry, w_set_dz;
    logic [W-1:0]    w_res_lo, w_res_hi;
    logic            w_unused;

    assign w_unused = &{1'b0, s00_axi.s00_axi_awprot, s00_axi.s00_axi_arprot,
                        s00_axi.s00_axi_awaddr[1:0], s00_axi.s00_axi_araddr[1:0]};

    // Ready outputs are registered, so the handshake cycle is the one where ready is high.
    assign w_wr    = r_awready && s00_axi.s00_axi_awvalid && s00_axi.s00_axi_wvalid;
    assign w_rd    = r_arready && s00_axi.s00_axi_arvalid;
    assign w_waddr = s00_axi.s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_raddr = s00_axi.s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_busy  = (r_state == S_EXEC) || (r_state == S_DIV);

    assign w_wmask = {{8{s00_axi.s00_axi_wstrb[3]}}, {8{s00_axi.s00_axi_wstrb[2]}},
                      {8{s00_axi.s00_axi_wstrb[1]}}, {8{s00_axi.s00_axi_wstrb[0]}}};
    assign w_wbits   = s00_axi.s00_axi_wdata & w_wmask;
    assign w_opa_nxt = (DW'(r_opa) & ~w_wmask) | w_wbits;
    assign w_opb_nxt = (DW'(r_opb) & ~w_wmask) | w_wbits;
    assign w_ctrl_op = s00_axi.s00_axi_wstrb[0] ? s00_axi.s00_axi_wdata[1:0] : r_op;
    assign w_clr     = (w_wr && w_waddr == A_ST && s00_axi.s00_axi_wstrb[0]) ?
                       s00_axi.s00_axi_wdata[3:1] : 3'b000;

    // Operand/CTRL writes during an op are refused so the running op stays coherent.
    assign w_wr_err = w_busy && (w_waddr == A_CTRL || w_waddr == A_OPA || w_waddr == A_OPB);
    assign w_start  = w_wr && !w_busy && (w_waddr == A_CTRL) &&
                      s00_axi.s00_axi_wstrb[1] && s00_axi.s00_axi_wdata[8];

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
    assign w_prod  = PW'(r_a) * PW'(r_b);
    // Restoring step: partial remainder < 2*divisor, so bit W of the trial flags a borrow.
    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_sub   = w_shift - {1'b0, r_b};

    always_comb begin
        w_state_nxt = r_state;
        w_fin       = 1'b0;
        w_set_carry = 1'b0;
        w_set_dz    = 1'b0;
        w_res_lo    = '0;
        w_res_hi    = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (w_start)
                    w_state_nxt = (w_ctrl_op == OP_DIV && r_opb != '0) ? S_DIV : S_EXEC;
            end
            S_EXEC: begin
                w_fin       = 1'b1;
                w_state_nxt = S_DONE;
                case (r_op_l)
                    OP_ADD: begin w_res_lo = w_sum[W-1:0];  w_set_carry = w_sum[W];  end
                    OP_SUB: begin w_res_lo = w_diff[W-1:0]; w_set_carry = w_diff[W]; end
                    OP_MUL: {w_res_hi, w_res_lo} = w_prod;
                    default: begin w_res_lo = '1; w_res_hi = r_a; w_set_dz = 1'b1; end
                endcase
            end
            S_DIV: begin
                if (r_cnt == CW'(W)) begin
                    w_fin       = 1'b1;
                    w_state_nxt = S_DONE;
                    w_res_lo    = r_quo;
                    w_res_hi    = r_rem;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (w_raddr)
            A_CTRL:  w_rdata = DW'(r_op);
            A_OPA:   w_rdata = DW'(r_opa);
            A_OPB:   w_rdata = DW'(r_opb);
            A_RLO:   w_rdata = DW'(r_res_lo);
            A_RHI:   w_rdata = DW'(r_res_hi);
            A_ST:    w_rdata = DW'({r_carry, r_dz, r_done, w_busy});
            A_IRQ:   w_rdata = DW'(r_irq_en);
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) r_state <= S_IDLE;
        else                  r_state <= w_state_nxt;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0; r_bvalid <= 1'b0; r_bresp <= 2'b00;
            r_arready <= 1'b0; r_rvalid <= 1'b0; r_rdata <= '0;
            r_op <= '0; r_op_l <= '0; r_opa <= '0; r_opb <= '0; r_a <= '0; r_b <= '0;
            r_res_lo <= '0; r_res_hi <= '0; r_quo <= '0; r_rem <= '0; r_cnt <= '0;
            r_done <= 1'b0; r_dz <= 1'b0; r_carry <= 1'b0; r_irq_en <= 1'b0;
        end else begin
            r_awready <= !r_awready && s00_axi.s00_axi_awvalid && s00_axi.s00_axi_wvalid && !r_bvalid;
            if (w_wr)                        r_bvalid <= 1'b1;
            else if (s00_axi.s00_axi_bready) r_bvalid <= 1'b0;
            r_arready <= !r_arready && s00_axi.s00_axi_arvalid && !r_rvalid;
            if (w_rd)                        r_rvalid <= 1'b1;
            else if (s00_axi.s00_axi_rready) r_rvalid <= 1'b0;
            if (w_rd) r_rdata <= w_rdata;

            if (w_wr) begin
                r_bresp <= w_wr_err ? 2'b10 : 2'b00;
                if (!w_wr_err) begin
                    case (w_waddr)
                        A_CTRL: r_op  <= w_ctrl_op;
                        A_OPA:  r_opa <= w_opa_nxt[W-1:0];
                        A_OPB:  r_opb <= w_opb_nxt[W-1:0];
`ifdef CALC_IRQ_EN
                        A_IRQ:  if (s00_axi.s00_axi_wstrb[0]) r_irq_en <= s00_axi.s00_axi_wdata[0];
`endif
                        default: ;
                    endcase
                end
            end

            if (w_start) begin
                r_a <= r_opa; r_b <= r_opb; r_op_l <= w_ctrl_op;
                r_quo <= r_opa; r_rem <= '0; r_cnt <= '0;
            end
            if (r_state == S_DIV && !w_fin) begin
                r_cnt <= r_cnt + 1'b1;
                r_quo <= {r_quo[W-2:0], ~w_sub[W]};
                r_rem <= w_sub[W] ? w_shift[W-1:0] : w_sub[W-1:0];
            end
            if (w_fin) begin
                r_res_lo <= w_res_lo;
                r_res_hi <= w_res_hi;
            end

            // Hardware set beats a same-cycle W1C.
            r_done  <= w_fin       || (r_done  && !w_clr[0]);
            r_dz    <= w_set_dz    || (r_dz    && !w_clr[1]);
            r_carry <= w_set_carry || (r_carry && !w_clr[2]);
        end
    end

`ifdef CALC_IRQ_EN
    logic r_irq;
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) r_irq <= 1'b0;
        else                  r_irq <= r_irq_en && r_done;
    end
    assign irq = r_irq;
`endif

    assign s00_axi.s00_axi_awready = r_awready;
    assign s00_axi.s00_axi_wready  = r_awready;
    assign s00_axi.s00_axi_bresp   = r_bresp;
    assign s00_axi.s00_axi_bvalid  = r_bvalid;
    assign s00_axi.s00_axi_arready = r_arready;
    assign s00_axi.s00_axi_rdata   = r_rdata;
    assign s00_axi.s00_axi_rresp   = 2'b00;
    assign s00_axi.s00_axi_rvalid  = r_rvalid;
endmodule

// File: tb/tb_calculator_axil_engine.sv
// tb/tb_calculator_axil_engine.sv - directed-vector bench for calculator_axil_engine
module tb_calculator_axil_engine;
    localparam logic [4:0] CTRL = 5'h00, OPA = 5'h04, OPB = 5'h08, RLO = 5'h0C;
    localparam logic [4:0] RHI  = 5'h10, ST  = 5'h14, IEN = 5'h18, RSV = 5'h1C;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    calculator_axil_engine_if #(.ADDR_W(5), .DATA_W(32)) bus ();
`ifdef CALC_IRQ_EN
    logic irq;
`endif

    calculator_axil_engine #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .OPERAND_WIDTH(32)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(aresetn),
        .s00_axi(bus)
`ifdef CALC_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_awready;
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.s00_axi_awready) begin ok = 1; break; end
        end
        if (!ok) check("awready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_arready;
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.s00_axi_arready) begin ok = 1; break; end
        end
        if (!ok) check("arready_timeout", 32'd0, 32'd1);
    endtask

    task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
        bus.s00_axi_awaddr  = a;
        bus.s00_axi_wdata   = d;
        bus.s00_axi_wstrb   = s;
        bus.s00_axi_awvalid = 1'b1;
        bus.s00_axi_wvalid  = 1'b1;
        bus.s00_axi_bready  = 1'b1;
        wait_awready();
        @(negedge clk);
        bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wvalid  = 1'b0;
        resp = bus.s00_axi_bresp;
        if (!bus.s00_axi_bvalid) check("bvalid_missing", 32'd0, 32'd1);
    endtask

    task automatic axi_rd(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        bus.s00_axi_araddr  = a;
        bus.s00_axi_arvalid = 1'b1;
        bus.s00_axi_rready  = 1'b1;
        wait_arready();
        @(negedge clk);
        bus.s00_axi_arvalid = 1'b0;
        d    = bus.s00_axi_rdata;
        resp = bus.s00_axi_rresp;
        if (!bus.s00_axi_rvalid) check("rvalid_missing", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [1:0] eresp);
        logic [1:0] r;
        axi_wr(a, d, 4'hF, r);
        check($sformatf("bresp@%02h", a), 32'(r), 32'(eresp));
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_rd(a, d, r);
        check(tag, d, exp);
    endtask

    task automatic wait_done;
        logic [31:0] d;
        logic [1:0]  r;
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            axi_rd(ST, d, r);
            if (d[1] && !d[0]) begin ok = 1; break; end
        end
        check("done_wait", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        bit          ok;
        bus.s00_axi_awaddr = '0; bus.s00_axi_awprot = '0; bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wdata = '0; bus.s00_axi_wstrb = '0; bus.s00_axi_wvalid = 1'b0;
        bus.s00_axi_bready = 1'b0; bus.s00_axi_araddr = '0; bus.s00_axi_arprot = '0;
        bus.s00_axi_arvalid = 1'b0; bus.s00_axi_rready = 1'b0;
        repeat (20) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        // Reset state of every register, RRESP OKAY
        for (int i = 0; i < 8; i++) begin
            axi_rd(5'(i * 4), d, r);
            check($sformatf("rst_rd_%02h", i * 4), d, 32'd0);
            check($sformatf("rst_rresp_%02h", i * 4), 32'(r), 32'd0);
        end

        // ADD with carry; STATUS sampled two cycles after START
        wr(OPA, 32'hFFFF_FFFF, OKAY);
        wr(OPB, 32'd2, OKAY);
        wr(CTRL, 32'h100, OKAY);
        rd_chk("add_status", ST, 32'hA);
        rd_chk("add_lo", RLO, 32'd1);
        rd_chk("add_hi", RHI, 32'd0);
        rd_chk("add_ctrl", CTRL, 32'd0);

        // SUB with borrow
        wr(ST, 32'hF, OKAY);
        wr(OPA, 32'd3, OKAY);
        wr(OPB, 32'd5, OKAY);
        wr(CTRL, 32'h101, OKAY);
        wait_done();
        rd_chk("sub_lo", RLO, 32'hFFFF_FFFE);
        rd_chk("sub_hi", RHI, 32'd0);
        rd_chk("sub_status", ST, 32'hA);
        rd_chk("sub_ctrl", CTRL, 32'd1);

        // MUL full product
        wr(OPA, 32'hFFFF_FFFF, OKAY);
        wr(OPB, 32'hFFFF_FFFF, OKAY);
        wr(CTRL, 32'h102, OKAY);
        wait_done();
        rd_chk("mul_hi", RHI, 32'hFFFF_FFFE);
        rd_chk("mul_lo", RLO, 32'h0000_0001);

        // DIV: still busy in the completion cycle (pre-update STATUS)
        wr(ST, 32'hF, OKAY);
        wr(OPA, 32'd100, OKAY);
        wr(OPB, 32'd7, OKAY);
        wr(CTRL, 32'h103, OKAY);
        repeat (31) @(negedge clk);
        rd_chk("div_busy_last", ST, 32'h1);
        wait_done();
        rd_chk("div_lo", RLO, 32'd14);
        rd_chk("div_hi", RHI, 32'd2);
        rd_chk("div_ctrl", CTRL, 32'd3);

        // DIV: DONE visible exactly one cycle later
        wr(ST, 32'hF, OKAY);
        wr(CTRL, 32'h103, OKAY);
        repeat (32) @(negedge clk);
        rd_chk("div_done_edge", ST, 32'h2);

        // DIV: W1C of DONE in the completion cycle loses to the set
        wr(ST, 32'hF, OKAY);
        wr(CTRL, 32'h103, OKAY);
        repeat (31) @(negedge clk);
        wr(ST, 32'h2, OKAY);
        rd_chk("done_set_wins", ST, 32'h2);

        // DIV: writes while busy are refused
        wr(OPA, 32'd200, OKAY);
        wr(CTRL, 32'h103, OKAY);
        wr(OPA, 32'h55, SLVERR);
        wr(CTRL, 32'h100, SLVERR);
        rd_chk("busy_opa_kept", OPA, 32'd200);
        wait_done();
        rd_chk("div2_lo", RLO, 32'd28);
        rd_chk("div2_hi", RHI, 32'd4);
        rd_chk("div2_ctrl", CTRL, 32'd3);

        // DIV by zero, then W1C of DONE|DZ
        wr(ST, 32'hF, OKAY);
        wr(OPA, 32'd5, OKAY);
        wr(OPB, 32'd0, OKAY);
        wr(CTRL, 32'h103, OKAY);
        rd_chk("dz_status", ST, 32'h6);
        rd_chk("dz_lo", RLO, 32'hFFFF_FFFF);
        rd_chk("dz_hi", RHI, 32'd5);
        wr(ST, 32'h6, OKAY);
        rd_chk("dz_cleared", ST, 32'h0);

        // Byte strobes, reserved word, read-only results
        wr(OPA, 32'h1122_3344, OKAY);
        axi_wr(OPA, 32'hAABB_CCDD, 4'h1, r);
        rd_chk("strb_0001", OPA, 32'h1122_33DD);
        axi_wr(OPA, 32'hAABB_CCDD, 4'hC, r);
        rd_chk("strb_1100", OPA, 32'hAABB_33DD);
        wr(RSV, 32'hFFFF_FFFF, OKAY);
        rd_chk("reserved_1c", RSV, 32'd0);
        wr(RLO, 32'h1234, OKAY);
        rd_chk("res_lo_ro", RLO, 32'hFFFF_FFFF);
        wr(IEN, 32'd1, OKAY);
`ifdef CALC_IRQ_EN
        rd_chk("irq_en_rd", IEN, 32'd1);
`else
        rd_chk("irq_en_rsvd", IEN, 32'd0);
`endif

        // Write-response backpressure; second AW must wait
        bus.s00_axi_bready  = 1'b0;
        bus.s00_axi_awaddr  = OPA; bus.s00_axi_wdata = 32'h1234; bus.s00_axi_wstrb = 4'hF;
        bus.s00_axi_awvalid = 1'b1; bus.s00_axi_wvalid = 1'b1;
        wait_awready();
        @(negedge clk);
        bus.s00_axi_awaddr = OPB; bus.s00_axi_wdata = 32'h5678;
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            if (!bus.s00_axi_bvalid || bus.s00_axi_bresp != OKAY || bus.s00_axi_awready) ok = 0;
            @(negedge clk);
        end
        check("b_backpressure", {31'd0, ok}, 32'd1);
        bus.s00_axi_bready = 1'b1;
        wait_awready();
        @(negedge clk);
        bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0;
        @(negedge clk);

        // Read-response backpressure; second AR must wait
        bus.s00_axi_rready  = 1'b0;
        bus.s00_axi_araddr  = OPA;
        bus.s00_axi_arvalid = 1'b1;
        wait_arready();
        @(negedge clk);
        bus.s00_axi_araddr = OPB;
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            if (!bus.s00_axi_rvalid || bus.s00_axi_rdata != 32'h1234 || bus.s00_axi_arready) ok = 0;
            @(negedge clk);
        end
        check("r_backpressure", {31'd0, ok}, 32'd1);
        check("r_bp_rdata", bus.s00_axi_rdata, 32'h1234);
        bus.s00_axi_rready = 1'b1;
        wait_arready();
        @(negedge clk);
        bus.s00_axi_arvalid = 1'b0;
        check("r_bp_second", bus.s00_axi_rdata, 32'h5678);
        @(negedge clk);

`ifdef CALC_IRQ_EN
        // irq follows DONE one cycle late and drops after the W1C
        wr(ST, 32'hF, OKAY);
        check("irq_idle", {31'd0, irq}, 32'd0);
        wr(CTRL, 32'h100, OKAY);
        check("irq_t1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_t2", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_t3", {31'd0, irq}, 32'd1);
        wr(ST, 32'h2, OKAY);
        check("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'd0);
`endif

        // Reset in the middle of a divide
        wr(ST, 32'hF, OKAY);
        wr(CTRL, 32'h103, OKAY);
        repeat (5) @(negedge clk);
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        rd_chk("midrst_status", ST, 32'd0);
        rd_chk("midrst_lo", RLO, 32'd0);
        rd_chk("midrst_opa", OPA, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
